// File: rtl/dp_tap_ctrl.sv
// IEEE 1149.1 TAP controller for the debug port: 16-state FSM, instruction register,
// capture/shift/update strobes for the data registers and the tdo mux.
module dp_tap_ctrl #(
  parameter int               width      = 8,
  parameter logic [width-1:0] IDCODE_INS = 8'h01,
  parameter logic [width-1:0] IR_CAPTURE = 8'h01
) (
  input  logic             tck,
  input  logic             trst,
  input  logic             tms,
  input  logic             tdi,
  input  logic             dr_tdo,
  output logic             tdo,
  output logic             tdo_oe,
  output logic [width-1:0] ir_out,
  output logic             capture_dr,
  output logic             shift_dr,
  output logic             update_dr,
  output logic             capture_ir,
  output logic             shift_ir,
  output logic             update_ir,
  output logic             tlr,
  output logic             run_idle
);

  // Encoding follows the customary 1149.1 state numbering for easier waveform reading.
  localparam logic [3:0] ST_EXIT2_DR = 4'h0;
  localparam logic [3:0] ST_EXIT1_DR = 4'h1;
  localparam logic [3:0] ST_SHIFT_DR = 4'h2;
  localparam logic [3:0] ST_PAUSE_DR = 4'h3;
  localparam logic [3:0] ST_SEL_IR   = 4'h4;
  localparam logic [3:0] ST_UPD_DR   = 4'h5;
  localparam logic [3:0] ST_CAP_DR   = 4'h6;
  localparam logic [3:0] ST_SEL_DR   = 4'h7;
  localparam logic [3:0] ST_EXIT2_IR = 4'h8;
  localparam logic [3:0] ST_EXIT1_IR = 4'h9;
  localparam logic [3:0] ST_SHIFT_IR = 4'hA;
  localparam logic [3:0] ST_PAUSE_IR = 4'hB;
  localparam logic [3:0] ST_RTI      = 4'hC;
  localparam logic [3:0] ST_UPD_IR   = 4'hD;
  localparam logic [3:0] ST_CAP_IR   = 4'hE;
  localparam logic [3:0] ST_TLR      = 4'hF;

  logic [3:0]       state_r;
  logic [3:0]       next_state_s;
  logic [width-1:0] ir_shift_r;
  logic [width-1:0] ir_out_r;

  // TAP next-state decode driven by tms
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_TLR:      next_state_s = tms ? ST_TLR      : ST_RTI;
      ST_RTI:      next_state_s = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   next_state_s = tms ? ST_SEL_IR   : ST_CAP_DR;
      ST_SEL_IR:   next_state_s = tms ? ST_TLR      : ST_CAP_IR;
      ST_CAP_DR:   next_state_s = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: next_state_s = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_EXIT1_DR: next_state_s = tms ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: next_state_s = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
      ST_EXIT2_DR: next_state_s = tms ? ST_UPD_DR   : ST_SHIFT_DR;
      ST_UPD_DR:   next_state_s = tms ? ST_SEL_DR   : ST_RTI;
      ST_CAP_IR:   next_state_s = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: next_state_s = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_EXIT1_IR: next_state_s = tms ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: next_state_s = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
      ST_EXIT2_IR: next_state_s = tms ? ST_UPD_IR   : ST_SHIFT_IR;
      ST_UPD_IR:   next_state_s = tms ? ST_SEL_DR   : ST_RTI;
      default:     next_state_s = ST_TLR;
    endcase
  end

  // State register and IR datapath; trst discards any partial shift
  always_ff @(posedge tck) begin
    if (trst) begin
      state_r    <= ST_TLR;
      ir_out_r   <= IDCODE_INS;
      ir_shift_r <= '0;
    end else begin
      state_r <= next_state_s;
      case (state_r)
        ST_CAP_IR:   ir_shift_r <= IR_CAPTURE;
        ST_SHIFT_IR: ir_shift_r <= {tdi, ir_shift_r[width-1:1]};
        ST_UPD_IR:   ir_out_r   <= ir_shift_r;
        ST_TLR:      ir_out_r   <= IDCODE_INS;
        default: begin
          ir_shift_r <= ir_shift_r;
          ir_out_r   <= ir_out_r;
        end
      endcase
    end
  end

  assign tlr        = (state_r == ST_TLR);
  assign run_idle   = (state_r == ST_RTI);
  assign capture_dr = (state_r == ST_CAP_DR);
  assign shift_dr   = (state_r == ST_SHIFT_DR);
  assign update_dr  = (state_r == ST_UPD_DR);
  assign capture_ir = (state_r == ST_CAP_IR);
  assign shift_ir   = (state_r == ST_SHIFT_IR);
  assign update_ir  = (state_r == ST_UPD_IR);

  assign ir_out = ir_out_r;
  assign tdo    = shift_ir ? ir_shift_r[0] : (shift_dr ? dr_tdo : 1'b0);
  assign tdo_oe = shift_ir | shift_dr;

endmodule

// File: tb/tb_dp_tap_ctrl.sv
// Directed self-checking bench for dp_tap_ctrl: reset, FSM walks, IR/DR scans, pause and reset mid-scan.
module tb_dp_tap_ctrl;

  logic       tck = 1'b0;
  logic       trst = 1'b1;
  logic       tms = 1'b0;
  logic       tdi = 1'b0;
  logic       dr_tdo = 1'b0;
  logic       tdo;
  logic       tdo_oe;
  logic [7:0] ir_out;
  logic       capture_dr, shift_dr, update_dr;
  logic       capture_ir, shift_ir, update_ir;
  logic       tlr, run_idle;
  logic [7:0] strb;

  int n_checks = 0;
  int n_fail   = 0;

  dp_tap_ctrl dut (
    .tck        (tck),
    .trst       (trst),
    .tms        (tms),
    .tdi        (tdi),
    .dr_tdo     (dr_tdo),
    .tdo        (tdo),
    .tdo_oe     (tdo_oe),
    .ir_out     (ir_out),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir),
    .tlr        (tlr),
    .run_idle   (run_idle)
  );

  // One-hot view of the strobes: tlr, rti, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir
  assign strb = {tlr, run_idle, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir};

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  exp3;
    logic [7:0]  a5;
    logic [7:0]  exp_sh;
    logic [31:0] pat;
    exp3 = 8'h01;
    a5   = 8'hA5;
    pat  = 32'hC3A5_0F96;

    // 1: reset
    trst = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("rst_strb", {24'd0, strb}, 32'h80);
    chk("rst_ir", {24'd0, ir_out}, 32'h01);
    chk("rst_tdo", {30'd0, tdo_oe, tdo}, 32'h0);
    trst = 1'b0;
    step(1'b1, 1'b0);
    chk("tlr_hold", {24'd0, strb}, 32'h80);

    // 2: into SHIFT_DR, then five tms=1 back to TLR
    step(1'b0, 1'b0);
    chk("rti", {24'd0, strb}, 32'h40);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("cap_dr", {24'd0, strb}, 32'h20);
    step(1'b0, 1'b0);
    chk("sh_dr", {24'd0, strb}, 32'h10);
    step(1'b1, 1'b0);
    chk("exit1_dr", {24'd0, strb}, 32'h00);
    step(1'b1, 1'b0);
    chk("upd_dr", {24'd0, strb}, 32'h08);
    step(1'b1, 1'b0);
    chk("sel_dr", {24'd0, strb}, 32'h00);
    step(1'b1, 1'b0);
    chk("sel_ir", {24'd0, strb}, 32'h00);
    step(1'b1, 1'b0);
    chk("tms5_tlr", {24'd0, strb}, 32'h80);
    chk("tms5_ir", {24'd0, ir_out}, 32'h01);

    // 3: IR scan of all ones
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("cap_ir", {24'd0, strb}, 32'h04);
    step(1'b0, 1'b0);
    chk("sh_ir", {24'd0, strb}, 32'h02);
    for (int i = 0; i < 8; i++) begin
      chk("ir_tdo", {30'd0, tdo_oe, tdo}, {30'd0, 1'b1, exp3[i]});
      step(i == 7, 1'b1);
    end
    chk("exit1_ir", {24'd0, strb}, 32'h00);
    step(1'b1, 1'b0);
    chk("upd_ir", {24'd0, strb}, 32'h01);
    chk("ir_before_upd", {24'd0, ir_out}, 32'h01);
    step(1'b0, 1'b0);
    chk("ir_ff", {24'd0, ir_out}, 32'hFF);

    // 4: DR scan, tdo follows dr_tdo
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("dr_cap", {24'd0, strb}, 32'h20);
    step(1'b0, 1'b0);
    chk("dr_cap_1cyc", {24'd0, strb}, 32'h10);
    for (int i = 0; i < 32; i++) begin
      dr_tdo = pat[i];
      #1;
      chk("dr_tdo", {30'd0, tdo_oe, tdo}, {30'd0, 1'b1, pat[i]});
      step(i == 31, 1'b0);
    end
    dr_tdo = 1'b1;
    #1;
    chk("dr_exit_tdo", {30'd0, tdo_oe, tdo}, 32'h0);
    step(1'b1, 1'b0);
    chk("dr_upd", {24'd0, strb}, 32'h08);
    step(1'b0, 1'b0);
    chk("dr_upd_1cyc", {24'd0, strb}, 32'h40);
    chk("dr_ir_keep", {24'd0, ir_out}, 32'hFF);
    dr_tdo = 1'b0;

    // 5: IR scan of A5 with a pause in the middle
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    exp_sh = 8'h01;
    for (int i = 0; i < 4; i++) begin
      chk("p_tdo_a", {30'd0, tdo_oe, tdo}, {30'd0, 1'b1, exp_sh[0]});
      step(i == 3, a5[i]);
      exp_sh = {a5[i], exp_sh[7:1]};
    end
    step(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("pause", {23'd0, strb, tdo_oe}, 32'h0);
      step(k == 2, 1'b1);
    end
    step(1'b0, 1'b1);
    chk("p_resume", {24'd0, strb}, 32'h02);
    for (int i = 4; i < 8; i++) begin
      chk("p_tdo_b", {30'd0, tdo_oe, tdo}, {30'd0, 1'b1, exp_sh[0]});
      step(i == 7, a5[i]);
      exp_sh = {a5[i], exp_sh[7:1]};
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("ir_a5", {24'd0, ir_out}, 32'hA5);

    // 6: reset in the middle of an IR scan
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    chk("mid_shift", {24'd0, strb}, 32'h02);
    trst = 1'b1;
    step(1'b0, 1'b1);
    chk("mid_rst_strb", {24'd0, strb}, 32'h80);
    chk("mid_rst_ir", {24'd0, ir_out}, 32'h01);
    trst = 1'b0;
    step(1'b0, 1'b0);
    chk("mid_rst_rti", {24'd0, strb}, 32'h40);
    chk("mid_rst_ir2", {24'd0, ir_out}, 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
